// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD read/write drivers: FSM states,
// RS encodings, default bus timing in clk cycles at 50 MHz.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    EHIGH,
    HOLD,
    ELOW,
    DONE
  } lcd_state_e;

  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;

  localparam int unsigned LCD_SETUP_CYC  = 2;
  localparam int unsigned LCD_E_HIGH_CYC = 12;
  localparam int unsigned LCD_HOLD_CYC   = 1;
  localparam int unsigned LCD_E_LOW_CYC  = 12;
  localparam int unsigned LCD_POLL_MAX   = 4096;

  // Width of a down-counter that must hold (longest phase - 1).
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/lcd_reader_if.sv
// Request/response and LCD pin bundle of the LCD reader. master = host side
// (drives requests and the pin value of DB), slave = the reader itself.
interface lcd_reader_if;
  // Handshake: a request is taken on a clk edge where start=1 and ready=1;
  // readData/pollMode are sampled on that same edge. valid is a one-cycle pulse
  // with dataOut/busyFlag/addrCounter/timeout already final; there is no backpressure.
  logic                     start;
  logic                     readData;
  logic                     pollMode;
  logic [7:0]               dataIn;
  logic                     RS;
  logic                     RW;
  logic                     enableOut;
  logic [7:0]               dataOut;
  logic                     busyFlag;
  logic [6:0]               addrCounter;
  logic                     valid;
  logic                     timeout;
  logic                     ready;
  lcd_pkg::lcd_state_e      dbgState;

  modport master (
    output start, readData, pollMode, dataIn,
    input  RS, RW, enableOut, dataOut, busyFlag, addrCounter, valid, timeout, ready, dbgState
  );

  modport slave (
    input  start, readData, pollMode, dataIn,
    output RS, RW, enableOut, dataOut, busyFlag, addrCounter, valid, timeout, ready, dbgState
  );
endinterface

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter that times one LCD bus phase; o_done is high while the
// count is zero, i.e. on the last cycle of a phase loaded with (cycles - 1).
module lcd_phase_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_done
);
  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);
endmodule

// File: rtl/lcd_reader.sv
// HD44780 read-cycle engine (RW=1): status reads with optional busy polling, and
// data reads. Define LCD_READER_NIBBLE_EN for the 4-bit bus (two E pulses per byte).
module lcd_reader import lcd_pkg::*; #(
  parameter int unsigned SETUP_CYC  = LCD_SETUP_CYC,   // must be >= 1
  parameter int unsigned E_HIGH_CYC = LCD_E_HIGH_CYC,
  parameter int unsigned HOLD_CYC   = LCD_HOLD_CYC,
  parameter int unsigned E_LOW_CYC  = LCD_E_LOW_CYC,
  parameter int unsigned POLL_MAX   = LCD_POLL_MAX
) (
  input  logic         clk,
  input  logic         rst,
  lcd_reader_if.slave  bus
);
  localparam int unsigned TW = timer_width(SETUP_CYC, E_HIGH_CYC, HOLD_CYC, E_LOW_CYC);
  localparam int unsigned PW = $clog2(POLL_MAX) + 1;

  lcd_state_e  r_state;
  logic        r_rs, r_rw, r_e, r_rd_data, r_poll;
  logic        r_valid, r_timeout, r_ready, r_bf;
  logic [7:0]  r_data;
  logic [6:0]  r_ac;
  logic [PW-1:0] r_poll_cnt;

  logic          w_load, w_done;
  logic [TW-1:0] w_load_val;
  logic [7:0]    w_byte;
  logic          w_byte_done, w_more_nib, w_below_max, w_repeat, w_timeout;

`ifdef LCD_READER_NIBBLE_EN
  logic [3:0] r_hi;
  logic       r_second;   // next (or current) E pulse carries the low nibble
  assign w_byte      = {r_hi, bus.dataIn[7:4]};
  assign w_byte_done = r_second;
  assign w_more_nib  = r_second;
`else
  assign w_byte      = bus.dataIn;
  assign w_byte_done = 1'b1;
  assign w_more_nib  = 1'b0;
`endif

  assign w_below_max = (r_poll_cnt < PW'(POLL_MAX));
  assign w_repeat    = r_poll & r_bf & w_below_max;
  assign w_timeout   = r_poll & r_bf & ~w_below_max;

  // The timer is reloaded for the phase being entered on every phase change.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    unique case (r_state)
      IDLE:  begin w_load = bus.start; w_load_val = TW'(SETUP_CYC - 1);  end
      SETUP: begin w_load = w_done;    w_load_val = TW'(E_HIGH_CYC - 1); end
      EHIGH: begin w_load = w_done;    w_load_val = TW'(HOLD_CYC - 1);   end
      HOLD:  begin w_load = w_done;    w_load_val = TW'(E_LOW_CYC - 1);  end
      ELOW:  begin w_load = w_done;    w_load_val = TW'(SETUP_CYC - 1);  end
      default: ;
    endcase
  end

  lcd_phase_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_value (w_load_val),
    .o_done  (w_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rs       <= RS_CMD;
      r_rw       <= 1'b0;
      r_e        <= 1'b0;
      r_rd_data  <= 1'b0;
      r_poll     <= 1'b0;
      r_valid    <= 1'b0;
      r_timeout  <= 1'b0;
      r_ready    <= 1'b1;
      r_bf       <= 1'b0;
      r_data     <= '0;
      r_ac       <= '0;
      r_poll_cnt <= '0;
`ifdef LCD_READER_NIBBLE_EN
      r_hi       <= '0;
      r_second   <= 1'b0;
`endif
    end else begin
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      unique case (r_state)
        IDLE: if (bus.start) begin
          r_rd_data  <= bus.readData;
          r_poll     <= bus.pollMode & ~bus.readData;
          r_rs       <= bus.readData ? RS_DATA : RS_CMD;
          r_rw       <= 1'b1;
          r_ready    <= 1'b0;
          r_poll_cnt <= '0;
`ifdef LCD_READER_NIBBLE_EN
          r_second   <= 1'b0;
`endif
          r_state    <= SETUP;
        end
        SETUP: if (w_done) begin
          r_e     <= 1'b1;
          r_state <= EHIGH;
        end
        EHIGH: if (w_done) begin
          r_e     <= 1'b0;
          r_state <= HOLD;
`ifdef LCD_READER_NIBBLE_EN
          r_second <= ~r_second;
          if (!r_second) r_hi <= bus.dataIn[7:4];
`endif
          if (w_byte_done) begin
            r_data <= w_byte;
            if (!r_rd_data) begin
              r_bf <= w_byte[7];
              r_ac <= w_byte[6:0];
            end
            if (r_poll_cnt != '1) r_poll_cnt <= r_poll_cnt + 1'b1;
          end
        end
        HOLD: if (w_done) begin
          if (w_more_nib || w_repeat) begin
            r_state <= ELOW;
          end else begin
            r_valid   <= 1'b1;
            r_timeout <= w_timeout;
            r_rs      <= RS_CMD;
            r_rw      <= 1'b0;
            r_state   <= DONE;
          end
        end
        ELOW: if (w_done) r_state <= SETUP;
        DONE: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.RS          = r_rs;
  assign bus.RW          = r_rw;
  assign bus.enableOut   = r_e;
  assign bus.dataOut     = r_data;
  assign bus.busyFlag    = r_bf;
  assign bus.addrCounter = r_ac;
  assign bus.valid       = r_valid;
  assign bus.timeout     = r_timeout;
  assign bus.ready       = r_ready;
  assign bus.dbgState    = r_state;
endmodule

// File: tb/tb_lcd_reader.sv
// Bench for lcd_reader: directed status/data/poll/reset/back-to-back cases plus
// random transactions against a byte-level LCD read model.
module tb_lcd_reader;
  localparam int PMAX      = 4;
  localparam int LAT1      = 16;
  localparam int PER_PULSE = 27;
  localparam int EH        = 12;
`ifdef LCD_READER_NIBBLE_EN
  localparam int PPB = 2;
`else
  localparam int PPB = 1;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_reader_if bus();
  lcd_reader #(.POLL_MAX(PMAX)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] pat[$];         // byte the LCD returns on each successive read
  int   pulse_cnt, hi_len, hi_min, hi_max, lo_len, first_gap, valid_cnt, rs_errs;
  logic prev_e = 1'b0;
  logic m_rs   = 1'b0;
  logic m_bf   = 1'b0;
  logic [6:0] m_ac = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pin_val(input int p);
    int b;
    logic [7:0] v;
    b = p / PPB;
    if (b >= pat.size()) b = pat.size() - 1;
    v = pat[b];
    if (PPB == 2 && (p % 2) == 1) v = {v[3:0], v[7:4]};
    return v;
  endfunction

  // LCD-side monitor: presents the next read value after each E fall and
  // measures pulse widths, gaps, RS stability and valid pulses.
  initial begin
    hi_len = 0; lo_len = 0; pulse_cnt = 0; first_gap = 0;
    valid_cnt = 0; rs_errs = 0; hi_min = 1000; hi_max = 0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.valid) valid_cnt++;
      if (bus.RW && bus.RS !== m_rs) rs_errs++;
      if (bus.enableOut) begin
        if (!prev_e && first_gap < 0) first_gap = lo_len;
        hi_len++;
      end else begin
        if (prev_e) begin
          if (hi_len < hi_min) hi_min = hi_len;
          if (hi_len > hi_max) hi_max = hi_len;
          pulse_cnt++;
          bus.dataIn = pin_val(pulse_cnt);
          lo_len = 0;
        end
        lo_len++;
        hi_len = 0;
      end
      prev_e = bus.enableOut;
    end
  end

  task automatic arm(input logic rd, input logic poll);
    pulse_cnt = 0; hi_min = 1000; hi_max = 0; first_gap = -1;
    valid_cnt = 0; rs_errs = 0;
    m_rs = rd;
    bus.dataIn   = pin_val(0);
    bus.start    = 1'b1;
    bus.readData = rd;
    bus.pollMode = poll;
  endtask

  // Driver + model: one read transaction over the bytes in pat.
  task automatic run_txn(input logic rd, input logic poll, input bit keep, input bit b2b);
    int n, lat, waits, exp_pulses;
    logic [7:0] b;
    bit to;
    n = 0;
    do begin
      b = pat[(n < pat.size()) ? n : pat.size() - 1];
      n++;
    end while (poll && !rd && b[7] && n < PMAX);
    to = poll && !rd && b[7];
    exp_pulses = n * PPB;
    exp_q.push_back(b);
    if (!rd) begin m_bf = b[7]; m_ac = b[6:0]; end

    arm(rd, poll);
    waits = 0;
    while (!bus.ready && waits < 100) begin @(negedge clk); waits++; end
    check("accept_ready", bus.ready, 1);
    if (b2b) check("b2b_accept_wait", waits, 1);
    @(posedge clk);
    @(negedge clk);
    if (!keep) bus.start = 1'b0;
    lat = 1;
    while (!bus.valid && lat < 4000) begin @(negedge clk); lat++; end
    check("latency", lat, LAT1 + (exp_pulses - 1) * PER_PULSE);
    check("dataOut", bus.dataOut, exp_q.pop_front());
    check("busyFlag", bus.busyFlag, m_bf);
    check("addrCounter", bus.addrCounter, m_ac);
    check("timeout", bus.timeout, to);
    check("rw_at_valid", bus.RW, 0);
    check("e_pulses", pulse_cnt, exp_pulses);
    check("e_high_min", hi_min, EH);
    check("e_high_max", hi_max, EH);
    check("rs_stable", rs_errs, 0);
    if (b2b) check("b2b_gap_ge5", first_gap >= 5, 1);
    if (!keep) begin
      @(negedge clk);
      check("ready_after", bus.ready, 1);
      check("valid_single", valid_cnt, 1);
      check("rw_after", bus.RW, 0);
    end
  endtask

  initial begin
    int nb;
    logic rd, poll;
    bus.start = 1'b0; bus.readData = 1'b0; bus.pollMode = 1'b0; bus.dataIn = '0;
    pat.push_back(8'h00);
    repeat (3) @(negedge clk);
    check("rst_RS", bus.RS, 0);
    check("rst_RW", bus.RW, 0);
    check("rst_E", bus.enableOut, 0);
    check("rst_dataOut", bus.dataOut, 0);
    check("rst_bf_ac", {bus.busyFlag, bus.addrCounter}, 0);
    check("rst_valid_to", {bus.valid, bus.timeout}, 0);
    check("rst_ready", bus.ready, 1);
    rst = 1'b0;
    @(negedge clk);

    pat = '{8'h85};                 run_txn(1'b0, 1'b0, 1'b0, 1'b0);
    pat = '{8'h41};                 run_txn(1'b1, 1'b0, 1'b0, 1'b0);
    pat = '{8'h80, 8'h80, 8'h80, 8'h12}; run_txn(1'b0, 1'b1, 1'b0, 1'b0);
    pat = '{8'hFF};                 run_txn(1'b0, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of the E-high phase.
    pat = '{8'h85};
    arm(1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    check("e_before_rst", bus.enableOut, 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_E", bus.enableOut, 0);
    check("abort_RW", bus.RW, 0);
    check("abort_ready", bus.ready, 1);
    rst = 1'b0;
    m_bf = 1'b0; m_ac = '0;
    repeat (30) @(negedge clk);
    check("abort_no_valid", valid_cnt, 0);
    pat = '{8'h23};                 run_txn(1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back with start held high.
    pat = '{8'h9A};                 run_txn(1'b0, 1'b0, 1'b1, 1'b0);
    pat = '{8'h3C};                 run_txn(1'b0, 1'b0, 1'b0, 1'b1);

    for (int t = 0; t < 20; t++) begin
      rd   = 1'($urandom_range(0, 1));
      poll = 1'($urandom_range(0, 1));
      pat.delete();
      if (poll && !rd) begin
        nb = $urandom_range(0, 5);
        for (int i = 0; i < nb; i++) pat.push_back({1'b1, 7'($urandom)});
        pat.push_back({1'b0, 7'($urandom)});
      end else begin
        pat.push_back(8'($urandom));
      end
      run_txn(rd, poll, 1'b0, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/lcd_reader.md
Name: lcd_reader

Overview:
- Read-side companion to the team's HD44780-style LCD write driver.
- Executes LCD read cycles (RW=1) with the 8-bit bus released by the FPGA:
  - RS=0 reads the busy flag plus address counter.
  - RS=1 reads DDRAM/CGRAM data.
- Optional busy-poll mode repeats status reads until BF clears, so the write driver can wait on real LCD readiness instead of fixed delays.
- Sits beside the write driver on the shared LCD pins; top level muxes RS/E and tristates the bus whenever RW=1.

Parameters:
- SETUP_CYC, 2, clk cycles RS/RW stable before E rises (tAS >= 40 ns at 50 MHz).
- E_HIGH_CYC, 12, clk cycles E held high; bus sampled on the last one (tPW/tDDR).
- HOLD_CYC, 1, clk cycles RS/RW held after E falls (tAH).
- E_LOW_CYC, 12, clk cycles E low between repeated pulses in poll mode or nibble mode.
- POLL_MAX, 4096, maximum status reads per poll request before timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  request pulse; accepted only when ready=1
- readData  in  1  0 = status read (RS=0), 1 = data read (RS=1); sampled with start
- pollMode  in  1  1 = repeat status reads until BF=0; ignored when readData=1; sampled with start
- dataIn  in  8  LCD DB[7:0] as seen at the pins
- RS  out  1  LCD register select
- RW  out  1  LCD read/write; 1 = LCD drives the bus, top level tristates
- enableOut  out  1  LCD E strobe
- dataOut  out  8  last sampled byte
- busyFlag  out  1  dataOut[7] of last status read
- addrCounter  out  7  dataOut[6:0] of last status read
- valid  out  1  one-cycle pulse when dataOut is updated and the transaction is complete
- timeout  out  1  one-cycle pulse, coincident with valid, when a poll ends on POLL_MAX
- ready  out  1  idle; start accepted

Behaviour:
- Reset state: state IDLE; outputs RS=0, RW=0, enableOut=0, dataOut=0, busyFlag=0, addrCounter=0, valid=0, timeout=0, ready=1.
- rst asserted mid-transaction aborts within one edge:
  - E falls immediately; RW returns to 0.
  - No valid pulse is generated.
  - A truncated E pulse is acceptable.
- States: IDLE -> SETUP -> EHIGH -> HOLD -> (ELOW -> SETUP when repeating) -> DONE -> IDLE.
- IDLE:
  - ready=1.
  - start=1 latches readData and pollMode, drives RS=readData and RW=1, goes to SETUP, and drops ready.
- SETUP: SETUP_CYC cycles, E=0. SETUP_CYC=0 is illegal; the minimum is 1.
- EHIGH:
  - E_HIGH_CYC cycles, E=1.
  - On the final cycle, register dataIn into dataOut; for status reads also update busyFlag and addrCounter.
- HOLD: HOLD_CYC cycles, E=0, RS/RW unchanged.
- Repeat decision at the end of HOLD:
  - Repeat if pollMode, status read, sampled BF=1, and poll count < POLL_MAX.
  - On repeat: ELOW for E_LOW_CYC cycles, then SETUP again. RS/RW stay asserted throughout.
- DONE:
  - Single cycle: valid=1, RW=0, RS=0.
  - If the poll count reached POLL_MAX with BF still 1: timeout=1.
  - Next cycle: IDLE, ready=1.
- Latency, single read with defaults: start accepted at edge N gives valid high in cycle N+SETUP_CYC+E_HIGH_CYC+HOLD_CYC+1 = N+16.
- Each extra poll iteration adds E_LOW_CYC+SETUP_CYC+E_HIGH_CYC+HOLD_CYC = 27 cycles.
- start while ready=0 is ignored; there is no queue.
- start in the same cycle as valid is ignored, since ready=0 in DONE.
- Poll counter is log2(POLL_MAX)+1 bits and saturates; it clears on every accepted start.
- Phase counter is one shared down-counter sized to the largest of the timing parameters.

Optional Feature:
- Macro: LCD_READER_NIBBLE_EN.
- Defined:
  - 4-bit interface; only dataIn[7:4] is used.
  - Each byte takes two E pulses, separated by ELOW: high nibble first, then low nibble.
  - valid/busyFlag update only after the second nibble.
  - BF is taken from the first nibble.
  - Default single-read latency becomes N+43.
- Undefined: 8-bit behaviour as above; dataIn[3:0] is used directly.

Decomposition:
- Package lcd_pkg:
  - State enum (IDLE, SETUP, EHIGH, HOLD, ELOW, DONE).
  - RS_CMD=0 and RS_DATA=1 constants.
  - Default timing constants, shared with the write driver.
- Sub-module lcd_phase_timer:
  - Loadable down-counter with a done flag.
  - Reusable by the write driver.

Test Plan:
- Status read: start, readData=0, pollMode=0, dataIn=8'h85 → RS=0, RW=1 during the transaction; E high exactly 12 cycles; valid in cycle N+16; dataOut=8'h85, busyFlag=1, addrCounter=7'h05; RW=0 afterward.
- Data read: readData=1, dataIn=8'h41 → RS=1 for the whole transaction; dataOut=8'h41; busyFlag/addrCounter unchanged from prior values.
- Busy poll: pollMode=1, dataIn=8'h80 for the first 3 samples, then 8'h12 → exactly 4 E pulses; single valid at N+16+3*27=N+97; busyFlag=0, addrCounter=7'h12; timeout=0.
- Poll timeout: POLL_MAX=4, dataIn held 8'hFF → 4 E pulses, then valid and timeout together; busyFlag=1.
- Reset mid-EHIGH: assert rst in cycle N+6 → next edge E=0, RW=0, ready=1; no valid pulse; a fresh start then completes normally.
- Back-to-back starts: start held high continuously → second transaction accepted the cycle after DONE (ready=1); E low gap ≥ SETUP_CYC+HOLD_CYC+2 cycles between pulses.
